// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port
// between a data-side and an instruction-side requester.
module mem_arbiter #(
  parameter int LATENCY = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [7:0] LOAD = 8'(LATENCY - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic        r_last_d;
  logic        r_sel_d;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_d_rdata;
  logic [31:0] r_i_rdata;
  logic        w_gnt_d;
  logic        w_gnt_i;
  logic        w_last;

  assign w_last = (r_state == S_BUSY) && (r_cnt == 8'd0);

  // Ties go to whichever side was not served last.
  always_comb begin
    w_next  = r_state;
    w_gnt_d = 1'b0;
    w_gnt_i = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (d_req && (!i_req || !r_last_d)) begin
          w_gnt_d = 1'b1;
          w_next  = S_BUSY;
        end else if (i_req) begin
          w_gnt_i = 1'b1;
          w_next  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == 8'd0) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_last_d  <= 1'b0;
      r_sel_d   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_d_rdata <= '0;
      r_i_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_gnt_d) begin
        r_sel_d  <= 1'b1;
        r_last_d <= 1'b1;
        r_we     <= d_we;
        r_addr   <= d_addr;
        r_wdata  <= d_wdata;
        r_cnt    <= LOAD;
      end else if (w_gnt_i) begin
        r_sel_d  <= 1'b0;
        r_last_d <= 1'b0;
        r_we     <= 1'b0;
        r_addr   <= i_addr;
        r_wdata  <= '0;
        r_cnt    <= LOAD;
      end else if (r_state == S_BUSY && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_last && !r_we) begin
        if (r_sel_d) r_d_rdata <= mem_rdata;
        else         r_i_rdata <= mem_rdata;
      end
    end
  end

  assign mem_en    = (r_state == S_BUSY);
  assign mem_we    = (r_state == S_BUSY) && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign d_done    = (r_state == S_DONE) && r_sel_d;
  assign i_done    = (r_state == S_DONE) && !r_sel_d;
  assign d_rdata   = r_d_rdata;
  assign i_rdata   = r_i_rdata;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 20, main-memory access time in cycles (legal range 1..255).
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 d_req  in  1  data-side request; held high until d_done.
REQ-005 d_we  in  1  data-side write (1) or read (0); sampled at grant.
REQ-006 d_addr  in  32  data-side word address; sampled at grant.
REQ-007 d_wdata  in  32  data-side write data; sampled at grant.
REQ-008 d_rdata  out  32  data-side read result; held until the next data-side read completes.
REQ-009 d_done  out  1  one-cycle pulse when the data-side transaction completes.
REQ-010 i_req  in  1  instruction-side refill request; held high until i_done.
REQ-011 i_addr  in  32  instruction-side word address; sampled at grant.
REQ-012 i_rdata  out  32  instruction-side read result; held until the next instruction-side completion.
REQ-013 i_done  out  1  one-cycle pulse when the instruction-side transaction completes.
REQ-014 mem_en  out  1  main-memory access active.
REQ-015 mem_we  out  1  main-memory write strobe.
REQ-016 mem_addr  out  32  main-memory address.
REQ-017 mem_wdata  out  32  main-memory write data.
REQ-018 mem_rdata  in  32  main-memory read data; valid in the last BUSY cycle.
REQ-019 busy  out  1  high whenever state is not IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, BUSY, DONE; only one transaction is outstanding at a time.
REQ-021 In IDLE, if only one of d_req/i_req is high, that requester SHALL be granted at the next edge.
REQ-022 In IDLE with both requests high, the requester not granted last SHALL win (round-robin); last_grant resets to instruction, so the data side wins the first tie.
REQ-023 At grant, the winner's address, write flag and write data SHALL be latched; requester inputs changing afterwards SHALL have no effect.
REQ-024 On entering BUSY, a down-counter SHALL load LATENCY-1 and decrement each BUSY cycle; when it reads 0 in BUSY, the next edge SHALL enter DONE.
REQ-025 BUSY SHALL last exactly LATENCY cycles; mem_en, mem_addr, mem_we, mem_wdata SHALL be driven from the latched values for all BUSY cycles and mem_en=0, mem_we=0 otherwise.
REQ-026 On the BUSY->DONE edge of a read, mem_rdata SHALL be captured into the granted side's rdata register; a write SHALL leave both rdata registers unchanged.
REQ-027 The granted side's done SHALL be high for exactly the DONE cycle; the other done SHALL stay low.
REQ-028 DONE SHALL always return to IDLE at the next edge; request inputs are ignored during DONE.
REQ-029 Latency: request high in IDLE cycle k -> done high in cycle k+1+LATENCY; the next grant is no earlier than cycle k+2+LATENCY.
REQ-030 A request dropped during BUSY SHALL NOT abort the transaction; it completes and done still pulses.
REQ-031 d_done and i_done SHALL never be high in the same cycle.
REQ-032 A requester that keeps req high through IDLE after its done SHALL be treated as a new request.

Reset
REQ-033 While reset is high at an edge, the FSM SHALL go to IDLE, the counter to 0, last_grant to instruction, and d_rdata, i_rdata, mem_addr and mem_wdata to 0.
REQ-034 While reset is high at an edge, d_done, i_done, mem_en, mem_we and busy SHALL be 0 from the next cycle, including reset asserted mid-BUSY; the aborted transaction produces no done.

Verification
REQ-035 LATENCY=4; d_req=1, d_we=0, d_addr=0x40 in cycle 0; mem_rdata=0xDEADBEEF -> mem_en high cycles 1-4 with mem_addr=0x40; d_done high only in cycle 5; d_rdata=0xDEADBEEF.
REQ-036 LATENCY=4; d_req and i_req both high from cycle 0 after reset -> data granted first (d_done cycle 5); instruction granted cycle 6, i_done cycle 11.
REQ-037 LATENCY=4; write d_we=1, d_addr=0x80, d_wdata=0x12345678 -> mem_we=1, mem_wdata=0x12345678 for 4 cycles; d_rdata keeps its prior value.
REQ-038 LATENCY=4; grant data, change d_addr to 0x99 and drop d_req in cycle 2 -> mem_addr stays at the latched address; d_done still pulses in cycle 5.
REQ-039 LATENCY=4; reset asserted in cycle 3 of BUSY -> from the next cycle busy=0, mem_en=0, no done pulse; a fresh i_req then completes normally.
REQ-040 LATENCY=1; alternating continuous d_req/i_req -> done pulses alternate, one every 3 cycles, never simultaneous.
